// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: decode-stage stall/forward control from a scoreboard of in-flight destinations; define HAZARD_FWD_EN for forwarding, otherwise stall-only
module pipe_hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int LW    = 2,
  parameter int CW    = 32,
  parameter int FW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] RsD,
  input  logic [AW-1:0] RtD,
  input  logic          UseRsD,
  input  logic          UseRtD,
  input  logic [AW-1:0] WriteRegD,
  input  logic          RegWriteD,
  input  logic [LW-1:0] LatD,
  input  logic          FlushD,
  output logic          Stall,
  output logic [FW-1:0] FwdA,
  output logic [FW-1:0] FwdB,
  output logic [CW-1:0] StallCount
);
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int MAXL = DEPTH - 1;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] dest_q [DEPTH];
  logic [AW-1:0] dest_d [DEPTH];
  logic [LW-1:0] lat_q [DEPTH];
  logic [LW-1:0] lat_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0][AW-1:0] src;
  logic [1:0] use_s, haz;
  logic [1:0][FW-1:0] fwd;
  assign src   = {RtD, RsD};
  assign use_s = {UseRtD, UseRsD};
  // per source, the youngest matching entry decides; scanning oldest-first lets it overwrite older matches
  always_comb begin
    haz = '0;
    fwd = '0;
    for (int s = 0; s < 2; s++)
      for (int i = DEPTH - 1; i >= 0; i--)
        if (use_s[s] && src[s] != '0 && valid_q[i] && dest_q[i] == src[s]) begin
          haz[s] = !FWD_EN || i < int'(lat_q[i]);
          fwd[s] = haz[s] ? '0 : FW'(i + 1);
        end
  end
  assign Stall      = !Reset && !FlushD && |haz;
  assign FwdA       = (Stall || Reset) ? '0 : fwd[0];
  assign FwdB       = (Stall || Reset) ? '0 : fwd[1];
  assign StallCount = cnt_q;
  // shift the scoreboard toward WB; a stalled or flushed decode slot enters as a bubble
  always_comb begin
    valid_d  = {valid_q[DEPTH-2:0], !Stall && !FlushD && RegWriteD && WriteRegD != '0};
    dest_d[0] = WriteRegD;
    lat_d[0]  = (int'(LatD) > MAXL) ? LW'(MAXL) : LatD;
    for (int i = 1; i < DEPTH; i++) begin
      dest_d[i] = dest_q[i-1];
      lat_d[i]  = lat_q[i-1];
    end
    cnt_d = (Stall && !(&cnt_q)) ? cnt_q + CW'(1) : cnt_q;
  end
  // valid bits and stall counter clear on reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  // payload fields are qualified by valid, so they need no reset
  always_ff @(posedge Clk) begin
    dest_q <= dest_d;
    lat_q  <= lat_d;
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed checks of stall, forwarding, flush and counter saturation
module tb_pipe_hazard_scoreboard;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, wr_d;
  logic       use_rs, use_rt, reg_wr, flush;
  logic [1:0] lat;
  logic       stall;
  logic [2:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;
  int total = 0;
  int bad = 0;

  pipe_hazard_scoreboard #(.DEPTH(3), .AW(5), .LW(2), .CW(4), .FW(3)) dut (
    .Clk(clk), .Reset(rst), .RsD(rs_d), .RtD(rt_d), .UseRsD(use_rs), .UseRtD(use_rt),
    .WriteRegD(wr_d), .RegWriteD(reg_wr), .LatD(lat), .FlushD(flush),
    .Stall(stall), .FwdA(fwd_a), .FwdB(fwd_b), .StallCount(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] wr, input logic rw, input logic [1:0] l, input logic fl);
    rs_d = rs; use_rs = urs; rt_d = rt; use_rt = urt;
    wr_d = wr; reg_wr = rw; lat = l; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic pair(input string tag, input logic [4:0] r, input logic [1:0] l, input bit on_b,
                      input int exp_st, input int exp_fwd);
    int n = 0;
    do_reset();
    drive(0, 0, 0, 0, r, 1, l, 0);
    chk({tag, "_prod_nostall"}, stall, 0);
    tick();
    drive(on_b ? 5'd0 : r, !on_b, on_b ? r : 5'd0, on_b, 0, 0, 0, 0);
    while (stall && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_stalls"}, n, exp_st);
    chk({tag, "_fwd"}, on_b ? fwd_b : fwd_a, exp_fwd);
    chk({tag, "_cnt"}, stall_cnt, exp_st);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      tick();
    end
    chk("rst_stall", stall, 0);
    chk("rst_fwda", fwd_a, 0);
    chk("rst_fwdb", fwd_b, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 1'b0;
    drive(8, 1, 9, 1, 0, 0, 0, 0);
    chk("rst_empty", stall, 0);

    pair("alu", 8, 1, 0, FWD ? 1 : 3, FWD ? 2 : 0);
    pair("load", 9, 2, 1, FWD ? 2 : 3, FWD ? 3 : 0);
    pair("clamp", 10, 3, 0, FWD ? 2 : 3, FWD ? 3 : 0);

    do_reset();
    drive(0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 6, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    drive(5, 1, 0, 0, 0, 0, 0, 0);
    chk("young_stall", stall, 1);
    chk("young_fwda", fwd_a, 0);
    tick();
    chk("young_next_stall", stall, FWD ? 0 : 1);
    chk("young_next_fwda", fwd_a, FWD ? 2 : 0);

    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    chk("r0_stall", stall, 0);
    chk("r0_fwda", fwd_a, 0);

    do_reset();
    drive(0, 0, 0, 0, 7, 1, 2, 0);
    tick();
    drive(7, 1, 0, 0, 3, 1, 1, 1);
    chk("flush_stall", stall, 0);
    tick();
    drive(3, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_bubble_stall", stall, 0);
    chk("flush_bubble_fwda", fwd_a, 0);
    chk("flush_cnt", stall_cnt, 0);

    do_reset();
    drive(8, 1, 0, 0, 8, 1, 2, 0);
    for (int k = 0; k < 40; k++) tick();
    chk("sat_cnt", stall_cnt, 15);
    n = 0;
    while (!stall && n < 10) begin
      tick();
      n++;
    end
    chk("sat_midstall", stall, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_stall", stall, 0);
    tick();
    chk("rst_mid_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_cleared", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
